mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Single-port memory controller directly downstream of the multicycle MIPS core.
//  Serves the core's instruction-fetch port and data port from one synchronous word RAM.
//  Arbitrates between the two ports, translates addresses, inserts wait states and
//  flags bad accesses. Issues exactly one RAM access per accepted request.
// PARAMETERS
//  BASE_ADDR    32'h80000000  byte address mapped to RAM word 0
//  ADDR_BITS    18            RAM word-address width (RAM size 2^ADDR_BITS words)
//  WAIT_STATES  0             extra cycles between RAM issue and response (0..15)
// PORTS
//  clk        in   1          clock; all logic on posedge
//  reset      in   1          synchronous, active-high
//  i_req      in   1          fetch request; held until i_valid
//  i_addr     in   32         fetch byte address
//  i_rdata    out  32         fetched instruction word
//  i_valid    out  1          1-cycle pulse: i_rdata valid / fetch complete
//  i_err      out  1          qualifies i_valid: fetch faulted
//  d_req      in   1          data request; held until d_valid
//  d_we       in   1          1=write, 0=read (core drives inverted data_rd_wr)
//  d_addr     in   32         data byte address
//  d_wdata    in   32         write data
//  d_be       in   4          byte enables, bit n = byte lane n
//  d_rdata    out  32         read data
//  d_valid    out  1          1-cycle pulse: access complete
//  d_err      out  1          qualifies d_valid: access faulted
//  ram_en     out  1          RAM access strobe
//  ram_we     out  4          RAM per-lane write enables
//  ram_addr   out  ADDR_BITS  RAM word address
//  ram_wdata  out  32         RAM write data
//  ram_rdata  in   32         RAM read data, valid 1 cycle after ram_en
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; fairness counter 0.
//  FSM: IDLE -> ISSUE -> WAIT (WAIT_STATES cycles; skipped if 0) -> RESP -> IDLE.
//   Faulted requests take IDLE -> RESP; the RAM is not touched.
//  IDLE: sample i_req/d_req; latch the granted port, address, we, be, wdata.
//  Arbitration: data wins. After 2 consecutive data grants with i_req pending,
//   the next grant goes to fetch. The counter clears on any fetch grant.
//  ISSUE: ram_en=1, ram_addr=(addr-BASE_ADDR)>>2. ram_we=be when a data write, else 0.
//   ram_wdata=latched wdata.
//  RESP: register rdata from ram_rdata (reads) or drive 0 (writes/faults).
//   Pulse valid (and err if faulted) on the granted port only.
//  Latency: request seen in IDLE at cycle N -> valid at N+2+WAIT_STATES; fault -> N+1.
//  Faults (err=1, rdata=0):
//   - addr<BASE_ADDR, or (addr-BASE_ADDR)>>2 >= 2^ADDR_BITS (32-bit subtract, no wrap);
//   - addr[1:0]!=0 on a fetch or data read;
//   - a write whose d_be is 0000, or is not one of the lane-aligned patterns
//     0001,0010,0100,1000,0011,1100,1111 at addr[1:0]=00/offsets.
//  Handshake: a requester drops req, or presents a new request, in the cycle after valid.
//   IDLE is entered the cycle after RESP, so a req still high there is a new request.
//  Simultaneous i_req and d_req: one is granted; the other stays pending; no request is lost.
//  Outputs other than valid/err hold their last value until the next RESP.
//  Reset mid-operation: return to IDLE next cycle; no valid pulse; ram_en/ram_we drop.
//   A RAM write already issued in ISSUE is not undone.
// STRUCTURE
//  mem_pkg: state enum (IDLE, ISSUE, WAIT, RESP), port-id enum (PORT_I, PORT_D),
//   legal byte-enable constants, default BASE_ADDR.
//  Sub-module mem_addr_check (combinational): addr, be, we, is_fetch -> fault.
//   Instantiated once, on the latched request.
// TESTING
//  1 fetch 0x80020000, RAM word 0x8000 = 0x27bdffe8 -> i_valid at N+2, i_rdata=0x27bdffe8, i_err=0.
//  2 d_req+i_req same cycle, 3 data requests back-to-back with i_req held
//    -> grant order D,D,I,D; each valid pulses once on the correct port.
//  3 write 0xdeadbeef, be=1111, addr 0x8011fffc; then read the same address
//    -> ram_we=1111, ram_addr=0x47fff; readback 0xdeadbeef.
//  4 read at 0x80020002, and fetch at 0x7ffffffc -> err=1, rdata=0 at N+1, ram_en never asserted.
//  5 WAIT_STATES=3 -> valid at N+5; reset asserted in WAIT
//    -> no valid, IDLE next cycle, following fetch serviced normally.
//  6 write be=0100 over 0x11223344 with wdata 0x00AA0000 -> readback 0x11AA3344.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the
// single-port instruction/data memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // Byte-enable pattern must sit on the lane the byte offset names.
  function automatic logic be_ok(
    input logic [3:0] be,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (be)
      BE_B0:   ok = (off == 2'd0);
      BE_B1:   ok = (off == 2'd1);
      BE_B2:   ok = (off == 2'd2);
      BE_B3:   ok = (off == 2'd3);
      BE_H0:   ok = (off == 2'd0);
      BE_H1:   ok = (off == 2'd2);
      BE_W:    ok = (off == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Address translation and fault detection
// for one request (fetch or data).
module mem_addr_check
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int ADDR_BITS = 18
) (
  input  logic [31:0]          addr,
  input  logic [3:0]           be,
  input  logic                 we,
  input  logic                 is_fetch,
  output logic [ADDR_BITS-1:0] word,
  output logic                 fault
);

  logic [31:0] off;
  logic below;
  logic beyond;
  logic misal;
  logic bad_be;

  assign off    = addr - BASE_ADDR;
  assign word   = off[ADDR_BITS+1:2];
  assign below  = addr < BASE_ADDR;
  assign beyond = |off[31:ADDR_BITS+2];
  assign misal  = (is_fetch || !we)
               && (off[1:0] != 2'b00);
  assign bad_be = !is_fetch && we
               && !be_ok(be, off[1:0]);
  assign fault  = below || beyond
               || misal || bad_be;

endmodule

// File: rtl/mem_ctrl.sv
// Fetch/data arbiter in front of one
// synchronous word RAM, with wait states.
module mem_ctrl
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int ADDR_BITS = 18,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic [31:0]          i_rdata,
  output logic                 i_valid,
  output logic                 i_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  input  logic [3:0]           d_be,
  output logic [31:0]          d_rdata,
  output logic                 d_valid,
  output logic                 d_err,
  output logic                 ram_en,
  output logic [3:0]           ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [31:0]          ram_wdata,
  input  logic [31:0]          ram_rdata
);

  localparam logic [3:0] WS_LAST =
    4'(WAIT_STATES - 1);
  localparam logic [1:0] FAIR_MAX = 2'd2;

  state_t state_q, state_d;
  port_t  port_q;
  logic   fault_q, we_q, issued_q;
  logic [3:0]  be_q, wcnt_q;
  logic [1:0]  fair_q;
  logic [31:0] wdata_q, cap_q;
  logic [31:0] i_hold_q, d_hold_q;
  logic [ADDR_BITS-1:0] waddr_q, g_word;
  logic [31:0] g_addr, resp_data;
  logic any_req, grant_i, g_we;
  logic g_fault, in_resp;

  // Fetch only beats a pending data
  // request once data has won twice.
  assign any_req = i_req || d_req;
  assign grant_i = i_req
    && (!d_req || fair_q == FAIR_MAX);
  assign g_addr = grant_i ? i_addr : d_addr;
  assign g_we   = !grant_i && d_we;

  mem_addr_check #(
    .BASE_ADDR(BASE_ADDR),
    .ADDR_BITS(ADDR_BITS)
  ) u_chk (
    .addr    (g_addr),
    .be      (d_be),
    .we      (g_we),
    .is_fetch(grant_i),
    .word    (g_word),
    .fault   (g_fault)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; faults bypass the RAM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (any_req)
          state_d = g_fault ? RESP : ISSUE;
      ISSUE:
        state_d = (WAIT_STATES == 0)
                ? RESP : WAIT;
      WAIT:
        if (wcnt_q == WS_LAST)
          state_d = RESP;
      RESP:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Latch the granted request and
  // track consecutive data wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_q  <= PORT_I;
      fault_q <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      fair_q  <= '0;
    end else if (state_q == IDLE && any_req) begin
      port_q  <= grant_i ? PORT_I : PORT_D;
      fault_q <= g_fault;
      we_q    <= g_we;
      be_q    <= d_be;
      wdata_q <= d_wdata;
      waddr_q <= g_word;
      if (grant_i || !i_req) fair_q <= '0;
      else fair_q <= fair_q + 2'd1;
    end
  end

  // Wait-state count; grab RAM data the
  // cycle after issue so it survives waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q   <= '0;
      issued_q <= 1'b0;
      cap_q    <= '0;
    end else begin
      wcnt_q   <= (state_q == WAIT)
                ? wcnt_q + 4'd1 : 4'd0;
      issued_q <= (state_q == ISSUE);
      if (issued_q) cap_q <= ram_rdata;
    end
  end

  assign in_resp   = (state_q == RESP);
  assign resp_data = (fault_q || we_q) ? '0
    : (WAIT_STATES == 0) ? ram_rdata : cap_q;

  // Read data holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else if (in_resp) begin
      if (port_q == PORT_I) i_hold_q <= resp_data;
      else                  d_hold_q <= resp_data;
    end
  end

  assign i_valid = in_resp && port_q == PORT_I;
  assign d_valid = in_resp && port_q == PORT_D;
  assign i_err   = i_valid && fault_q;
  assign d_err   = d_valid && fault_q;
  assign i_rdata = i_valid ? resp_data : i_hold_q;
  assign d_rdata = d_valid ? resp_data : d_hold_q;

  assign ram_en    = (state_q == ISSUE);
  assign ram_we    = (ram_en && we_q) ? be_q : 4'b0;
  assign ram_addr  = waddr_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: one instance with no
// wait states, one with three, each with a RAM model.
module tb_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int failed = 0;

  logic reset0, reset1;
  logic i_req0, i_req1;
  logic [31:0] i_addr0, i_addr1;
  logic [31:0] i_rdata0, i_rdata1;
  logic i_valid0, i_valid1, i_err0, i_err1;
  logic d_req0, d_req1, d_we0, d_we1;
  logic [31:0] d_addr0, d_addr1;
  logic [31:0] d_wdata0, d_wdata1;
  logic [3:0] d_be0, d_be1;
  logic [31:0] d_rdata0, d_rdata1;
  logic d_valid0, d_valid1, d_err0, d_err1;
  logic ram_en0, ram_en1;
  logic [3:0] ram_we0, ram_we1;
  logic [18:0] ram_addr0;
  logic [17:0] ram_addr1;
  logic [31:0] ram_wdata0, ram_wdata1;
  logic [31:0] ram_rdata0, ram_rdata1;

  mem_ctrl #(
    .BASE_ADDR(32'h8000_0000),
    .ADDR_BITS(19),
    .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .reset(reset0),
    .i_req(i_req0), .i_addr(i_addr0),
    .i_rdata(i_rdata0), .i_valid(i_valid0),
    .i_err(i_err0),
    .d_req(d_req0), .d_we(d_we0),
    .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_be(d_be0), .d_rdata(d_rdata0),
    .d_valid(d_valid0), .d_err(d_err0),
    .ram_en(ram_en0), .ram_we(ram_we0),
    .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0),
    .ram_rdata(ram_rdata0)
  );

  mem_ctrl #(
    .BASE_ADDR(32'h8000_0000),
    .ADDR_BITS(18),
    .WAIT_STATES(3)
  ) dut1 (
    .clk(clk), .reset(reset1),
    .i_req(i_req1), .i_addr(i_addr1),
    .i_rdata(i_rdata1), .i_valid(i_valid1),
    .i_err(i_err1),
    .d_req(d_req1), .d_we(d_we1),
    .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_be(d_be1), .d_rdata(d_rdata1),
    .d_valid(d_valid1), .d_err(d_err1),
    .ram_en(ram_en1), .ram_we(ram_we1),
    .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1),
    .ram_rdata(ram_rdata1)
  );

  logic [31:0] mem0 [0:524287];
  logic [31:0] mem1 [0:262143];
  int en_cnt0 = 0;
  int en_cnt1 = 0;

  // Synchronous RAM models with lane writes.
  always @(posedge clk) begin
    if (ram_en0) begin
      for (int b = 0; b < 4; b++)
        if (ram_we0[b])
          mem0[ram_addr0][8*b +: 8] <= ram_wdata0[8*b +: 8];
      ram_rdata0 <= mem0[ram_addr0];
      en_cnt0 <= en_cnt0 + 1;
    end
    if (ram_en1) begin
      for (int b = 0; b < 4; b++)
        if (ram_we1[b])
          mem1[ram_addr1][8*b +: 8] <= ram_wdata1[8*b +: 8];
      ram_rdata1 <= mem1[ram_addr1];
      en_cnt1 <= en_cnt1 + 1;
    end
  end

  task automatic check(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic set_req(
    input int u, input bit is_i, input bit r,
    input bit we, input logic [31:0] a,
    input logic [31:0] w, input logic [3:0] be
  );
    if (u == 0) begin
      if (is_i) begin
        i_req0 = r; i_addr0 = a;
      end else begin
        d_req0 = r; d_we0 = we; d_addr0 = a;
        d_wdata0 = w; d_be0 = be;
      end
    end else begin
      if (is_i) begin
        i_req1 = r; i_addr1 = a;
      end else begin
        d_req1 = r; d_we1 = we; d_addr1 = a;
        d_wdata1 = w; d_be1 = be;
      end
    end
  endtask

  // {valid, err, other valid, ram_en, rdata}
  function automatic logic [35:0] peek(
    input int u, input bit is_i
  );
    logic v, e, ov, en;
    logic [31:0] rd;
    if (u == 0) begin
      v  = is_i ? i_valid0 : d_valid0;
      e  = is_i ? i_err0   : d_err0;
      ov = is_i ? d_valid0 : i_valid0;
      rd = is_i ? i_rdata0 : d_rdata0;
      en = ram_en0;
    end else begin
      v  = is_i ? i_valid1 : d_valid1;
      e  = is_i ? i_err1   : d_err1;
      ov = is_i ? d_valid1 : i_valid1;
      rd = is_i ? i_rdata1 : d_rdata1;
      en = ram_en1;
    end
    return {v, e, ov, en, rd};
  endfunction

  // One request from IDLE to completion, then back in IDLE.
  task automatic xact(
    input int u, input bit is_i, input bit we,
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] be, input logic [31:0] exp,
    input bit exp_err, input int exp_lat,
    input string tag,
    output logic [3:0] swe, output logic [31:0] saddr
  );
    int n;
    int en0;
    int en1;
    logic [35:0] p;
    n = 0;
    swe = '0;
    saddr = '0;
    en0 = (u == 0) ? en_cnt0 : en_cnt1;
    set_req(u, is_i, 1'b1, we, addr, wdata, be);
    do begin
      @(negedge clk);
      n++;
      p = peek(u, is_i);
      if (p[32]) begin
        swe   = (u == 0) ? ram_we0 : ram_we1;
        saddr = (u == 0) ? 32'(ram_addr0)
                         : 32'(ram_addr1);
      end
    end while (!p[35] && n < 30);
    set_req(u, is_i, 1'b0, we, addr, wdata, be);
    en1 = (u == 0) ? en_cnt0 : en_cnt1;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_err"}, 32'(p[34]), 32'(exp_err));
    check({tag, "_rdata"}, p[31:0], exp);
    check({tag, "_other"}, 32'(p[33]), 32'd0);
    check({tag, "_ram_acc"}, 32'(en1 - en0),
          exp_err ? 32'd0 : 32'd1);
    @(negedge clk);
    p = peek(u, is_i);
    check({tag, "_pulse"}, 32'(p[35]), 32'd0);
  endtask

  logic [3:0] swe;
  logic [31:0] saddr;
  logic [3:0] ord;
  int k, dn, n, vcnt;
  bit both;

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);

    check("rst0_ctl", {24'd0, i_valid0, i_err0, d_valid0,
          d_err0, ram_en0, 3'd0}, 32'd0);
    check("rst0_we", 32'(ram_we0), 32'd0);
    check("rst0_addr", 32'(ram_addr0), 32'd0);
    check("rst0_rd", i_rdata0 | d_rdata0, 32'd0);
    check("rst1_ctl", {24'd0, i_valid1, i_err1, d_valid1,
          d_err1, ram_en1, 3'd0}, 32'd0);
    check("rst1_rd", i_rdata1 | d_rdata1, 32'd0);
    reset0 = 1'b0; reset1 = 1'b0;
    @(negedge clk);

    // fetch after a data write of the instruction
    xact(0, 0, 1, 32'h8002_0000, 32'h27bd_ffe8, 4'hf,
         32'h0, 0, 2, "t1_wr", swe, saddr);
    check("t1_wr_addr", saddr, 32'h8000);
    xact(0, 1, 0, 32'h8002_0000, 32'h0, 4'h0,
         32'h27bd_ffe8, 0, 2, "t1_fetch", swe, saddr);

    // full word write and readback
    xact(0, 0, 1, 32'h8011_fffc, 32'hdead_beef, 4'hf,
         32'h0, 0, 2, "t3_wr", swe, saddr);
    check("t3_we", 32'(swe), 32'hf);
    check("t3_addr", saddr, 32'h47fff);
    xact(0, 0, 0, 32'h8011_fffc, 32'h0, 4'hf,
         32'hdead_beef, 0, 2, "t3_rd", swe, saddr);
    check("t3_rd_we", 32'(swe), 32'h0);

    // single-lane merge
    xact(0, 0, 1, 32'h8000_0100, 32'h1122_3344, 4'hf,
         32'h0, 0, 2, "t6_wr", swe, saddr);
    xact(0, 0, 1, 32'h8000_0102, 32'h00aa_0000, 4'b0100,
         32'h0, 0, 2, "t6_lane", swe, saddr);
    check("t6_we", 32'(swe), 32'b0100);
    check("t6_addr", saddr, 32'h40);
    xact(0, 0, 0, 32'h8000_0100, 32'h0, 4'hf,
         32'h11aa_3344, 0, 2, "t6_rd", swe, saddr);

    // faults: bad byte enables, misalignment, range
    xact(0, 0, 1, 32'h8000_0100, 32'h0, 4'b0100,
         32'h0, 1, 1, "be_lane", swe, saddr);
    xact(0, 0, 1, 32'h8000_0100, 32'h0, 4'b0000,
         32'h0, 1, 1, "be_zero", swe, saddr);
    xact(0, 0, 1, 32'h8000_0100, 32'h0, 4'b0101,
         32'h0, 1, 1, "be_odd", swe, saddr);
    xact(0, 0, 0, 32'h8002_0002, 32'h0, 4'hf,
         32'h0, 1, 1, "t4_misal", swe, saddr);
    xact(0, 1, 0, 32'h7fff_fffc, 32'h0, 4'h0,
         32'h0, 1, 1, "t4_below", swe, saddr);
    xact(0, 0, 0, 32'h8020_0000, 32'h0, 4'hf,
         32'h0, 1, 1, "top_over", swe, saddr);
    xact(0, 0, 1, 32'h801f_fffc, 32'h5a5a_0001, 4'hf,
         32'h0, 0, 2, "top_last", swe, saddr);
    check("top_last_addr", saddr, 32'h7ffff);

    // arbitration: D, D, I, D
    ord = '0; k = 0; dn = 0; n = 0; both = 0;
    set_req(0, 0, 1, 0, 32'h8011_fffc, 32'h0, 4'hf);
    set_req(0, 1, 1, 0, 32'h8002_0000, 32'h0, 4'h0);
    while (k < 4 && n < 60) begin
      @(negedge clk);
      n++;
      if (d_valid0 && i_valid0) both = 1;
      if (d_valid0) begin
        ord = {ord[2:0], 1'b1};
        k++; dn++;
        check("arb_d_rd", d_rdata0, 32'hdead_beef);
        if (dn == 3) d_req0 = 1'b0;
      end else if (i_valid0) begin
        ord = {ord[2:0], 1'b0};
        k++;
        check("arb_i_rd", i_rdata0, 32'h27bd_ffe8);
        i_req0 = 1'b0;
      end
    end
    check("arb_order", 32'(ord), 32'b1101);
    check("arb_count", 32'(k), 32'd4);
    check("arb_both", 32'(both), 32'd0);
    @(negedge clk);

    // three wait states
    xact(1, 0, 1, 32'h8000_0000, 32'h1234_5678, 4'hf,
         32'h0, 0, 5, "t5_wr", swe, saddr);
    xact(1, 1, 0, 32'h8000_0000, 32'h0, 4'h0,
         32'h1234_5678, 0, 5, "t5_fetch", swe, saddr);
    xact(1, 1, 0, 32'h8011_fffc, 32'h0, 4'h0,
         32'h0, 1, 1, "t5_range", swe, saddr);

    // reset while waiting
    set_req(1, 1, 1, 0, 32'h8000_0000, 32'h0, 4'h0);
    @(negedge clk);
    check("t5_issue", 32'(ram_en1), 32'd1);
    @(negedge clk);
    check("t5_wait", 32'(ram_en1), 32'd0);
    reset1 = 1'b1;
    i_req1 = 1'b0;
    @(negedge clk);
    check("t5_rst_v", 32'(i_valid1), 32'd0);
    check("t5_rst_en", {27'd0, ram_en1, ram_we1}, 32'd0);
    reset1 = 1'b0;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_valid1 || d_valid1) vcnt++;
    end
    check("t5_no_valid", 32'(vcnt), 32'd0);
    xact(1, 1, 0, 32'h8000_0000, 32'h0, 4'h0,
         32'h1234_5678, 0, 5, "t5_after", swe, saddr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
